// File: rtl/locked_reg_access_ctrl_if.sv
// Requester-side bus for the lockable register controller: per-requester
// request attributes in, one-hot grant and a single response channel out.
interface locked_reg_access_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_trusted;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rsp_valid;
    logic                      rsp_err;
    logic [ID_W-1:0]           rsp_id;

    modport master (
        output req, req_we, req_lock, req_trusted, req_wdata,
        input  gnt, rsp_valid, rsp_err, rsp_id
    );

    modport slave (
        input  req, req_we, req_lock, req_trusted, req_wdata,
        output gnt, rsp_valid, rsp_err, rsp_id
    );
endinterface

// File: rtl/locked_reg_access_ctrl.sv
// Round-robin arbiter in front of a sticky-lockable protected register.
// One transaction every three cycles: IDLE (arbitrate) -> COMMIT -> RESP.
module locked_reg_access_ctrl #(
    parameter int                NUM_REQ   = 4,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       Clk,
    input  logic                       reset,
    locked_reg_access_ctrl_if.slave    bus,
    output logic [DATA_W-1:0]          Data_out,
    output logic                       lock_status,
    output logic [7:0]                 viol_cnt
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_RESP
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   cap_id;
    logic              cap_we;
    logic              cap_lock;
    logic              cap_trusted;
    logic [DATA_W-1:0] cap_wdata;
    logic              err_q;

    // Round-robin search upward from rr_ptr+1 with wrap; scanning from the
    // farthest offset down lets the nearest set bit overwrite the rest.
    always_comb begin
        int idx;
        idx    = 0;
        win_id = rr_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req[idx]) win_id = ID_W'(idx);
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output is given a default before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.gnt       = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_id    = '0;
        case (state)
            S_IDLE: begin
                if (|bus.req) state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                bus.gnt[cap_id] = 1'b1;
                state_nxt       = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                bus.rsp_id    = cap_id;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            cap_id      <= '0;
            cap_we      <= 1'b0;
            cap_lock    <= 1'b0;
            cap_trusted <= 1'b0;
            cap_wdata   <= '0;
            err_q       <= 1'b0;
            Data_out    <= RESET_VAL;
            lock_status <= 1'b0;
            viol_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        rr_ptr      <= win_id;
                        cap_id      <= win_id;
                        cap_we      <= bus.req_we[win_id];
                        cap_lock    <= bus.req_lock[win_id];
                        cap_trusted <= bus.req_trusted[win_id];
                        cap_wdata   <= bus.req_wdata[int'(win_id)*DATA_W +: DATA_W];
                        err_q       <= 1'b0;
                    end
                end
                S_COMMIT: begin
                    // The write is judged against the lock as it stood before
                    // this transaction, so write+lock from anyone lands first.
                    if (cap_we) begin
                        if (!lock_status || cap_trusted) begin
                            Data_out <= cap_wdata;
                        end else begin
                            err_q <= 1'b1;
                            if (viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
                        end
                    end
                    if (cap_lock) lock_status <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
